// File: rtl/clk_break_ctrl_if.sv
// Host command channel for the clock-break run-control engine.
// The host drives valid/op/arg; the controller answers with ready.
interface clk_break_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_arg;

   modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/clk_break_ctrl.sv
// Debug run-control engine that produces the registered full_break stop
// request for the DUT clock gate, and counts the DUT edges actually delivered.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_HALTED  | DUT clock stopped; waits for a host command
// ST_RUN     | free running until a host command or a break condition
// ST_STEP    | delivers step_rem more edges, then halts with STEP_DONE
// ST_BROKEN  | stopped by FIFO back-pressure; may auto-resume to resume_mode
module clk_break_ctrl #(
   parameter int LVL_W       = 11,
   parameter int HIGH_WM     = 1000,
   parameter int LOW_WM      = 512,
   parameter int AUTO_RESUME = 1,
   parameter int CNT_W       = 64
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               clk_en,
   clk_break_ctrl_if.slave    cmd,
   input  logic               ext_break,
   input  logic [LVL_W-1:0]   fifo_level,
   output logic               full_break,
   output logic [1:0]         run_state,
   output logic [2:0]         break_cause,
   output logic [CNT_W-1:0]   cycle_cnt
);

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_BROKEN = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE      = 3'd0,
      CAUSE_HOST      = 3'd1,
      CAUSE_STEP_DONE = 3'd2,
      CAUSE_EXT       = 3'd3,
      CAUSE_FIFO      = 3'd4
   } cause_t;

   localparam logic [1:0]       OP_HALT  = 2'd0;
   localparam logic [1:0]       OP_RUN   = 2'd1;
   localparam logic [1:0]       OP_STEP  = 2'd2;
   localparam logic [1:0]       OP_CLR   = 2'd3;
   localparam logic [LVL_W-1:0] HIGH_LVL = LVL_W'(HIGH_WM);
   localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(LOW_WM);

   state_t            state_q, state_d;
   state_t            resume_q, resume_d;
   cause_t            cause_q, cause_d;
   logic [31:0]       rem_q, rem_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q;
   logic              full_break_q, full_break_d;
   logic              dut_edge;
   logic              accept;
   logic              fifo_hi;
   logic              fifo_lo;

   assign dut_edge = clk_en & ~full_break_q;
   assign accept   = cmd.cmd_valid & ready_q;
   assign fifo_hi  = (fifo_level >= HIGH_LVL);
   assign fifo_lo  = (fifo_level <= LOW_LVL);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q      <= ST_HALTED;
         resume_q     <= ST_RUN;
         cause_q      <= CAUSE_HOST;
         rem_q        <= 32'd0;
         cnt_q        <= '0;
         ready_q      <= 1'b1;
         full_break_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         resume_q     <= resume_d;
         cause_q      <= cause_d;
         rem_q        <= rem_d;
         cnt_q        <= cnt_d;
         ready_q      <= ~accept;
         full_break_q <= full_break_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      resume_d = resume_q;
      cause_d  = cause_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;

      // An edge taken while stepping always consumes budget, even if a break fires.
      if (dut_edge && state_q == ST_STEP) begin
         rem_d = rem_q - 32'd1;
      end

      case (state_q)
         ST_RUN, ST_STEP: begin
            if (ext_break) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_EXT;
            end else if (fifo_hi) begin
               state_d  = ST_BROKEN;
               cause_d  = CAUSE_FIFO;
               resume_d = state_q;
            end else if (state_q == ST_STEP && dut_edge && rem_q == 32'd1) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_STEP_DONE;
            end
         end
         ST_BROKEN: begin
            if (ext_break) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_EXT;
            end else if (AUTO_RESUME != 0 && fifo_lo) begin
               // A step whose last edge coincided with the FIFO break has nothing left to run.
               if (resume_q == ST_STEP && rem_q == 32'd0) begin
                  state_d = ST_HALTED;
                  cause_d = CAUSE_STEP_DONE;
               end else begin
                  state_d = resume_q;
                  cause_d = CAUSE_NONE;
               end
            end
         end
         default: ;
      endcase

      // Accepted host commands override any break or resume decision this cycle;
      // CLR_CNT leaves run-state bookkeeping to the logic above.
      if (accept) begin
         case (cmd.cmd_op)
            OP_HALT: begin
               state_d = ST_HALTED;
               cause_d = CAUSE_HOST;
            end
            OP_RUN: begin
               state_d = ST_RUN;
               cause_d = CAUSE_NONE;
            end
            OP_STEP: begin
               rem_d = cmd.cmd_arg;
               if (cmd.cmd_arg == 32'd0) begin
                  state_d = ST_HALTED;
                  cause_d = CAUSE_STEP_DONE;
               end else begin
                  state_d = ST_STEP;
                  cause_d = CAUSE_NONE;
               end
            end
            default: ;
         endcase
      end

      if (accept && cmd.cmd_op == OP_CLR) begin
         cnt_d = '0;
      end else if (dut_edge) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      full_break_d = ~((state_d == ST_RUN) || (state_d == ST_STEP && rem_d != 32'd0));
   end

   assign cmd.cmd_ready = ready_q;
   assign full_break    = full_break_q;
   assign run_state     = state_q;
   assign break_cause   = cause_q;
   assign cycle_cnt     = cnt_q;

endmodule
